// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage dynamic branch predictor. A combined BTB and 2-bit
//               direction table with bimodal or gshare indexing. Lookup is
//               combinational on pc_f. Training comes from Execute. Saturating
//               counters track resolved branches and mispredictions.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int MODE       = 0,
    parameter int HIST_BITS  = 4,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       pc_f,
    output logic                        pred_taken_f,
    output logic [DATA_WIDTH-1:0]       pred_target_f,
    output logic                        pred_hit_f,
    output logic [$clog2(ENTRIES)-1:0]  pred_idx_f,
    input  logic                        upd_valid_e,
    input  logic [DATA_WIDTH-1:0]       upd_pc_e,
    input  logic [$clog2(ENTRIES)-1:0]  upd_idx_e,
    input  logic                        upd_is_jump_e,
    input  logic                        upd_taken_e,
    input  logic [DATA_WIDTH-1:0]       upd_target_e,
    input  logic                        upd_mispred_e,
    output logic [CNT_W-1:0]            perf_branch_cnt,
    output logic [CNT_W-1:0]            perf_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);

    // Table storage
    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [DATA_WIDTH-1:0] target_d [ENTRIES];
    logic                  jump_q   [ENTRIES];
    logic                  jump_d   [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            ctr_d    [ENTRIES];

    // Global history; held at zero in bimodal mode so it folds away
    logic [HIST_BITS-1:0]  ghr_q;
    logic [HIST_BITS-1:0]  ghr_d;

    logic [CNT_W-1:0]      br_cnt_q;
    logic [CNT_W-1:0]      br_cnt_d;
    logic [CNT_W-1:0]      mp_cnt_q;
    logic [CNT_W-1:0]      mp_cnt_d;

    logic [IDX_W-1:0]      w_ghr_ext;
    logic [IDX_W-1:0]      w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd_hit;

    // Lookup: index, tag compare and next-PC selection, gated off while in reset
    always_comb begin
        w_ghr_ext     = (MODE == 1) ? IDX_W'(ghr_q) : '0;
        w_lk_idx      = pc_f[IDX_W+1:2] ^ w_ghr_ext;
        w_lk_tag      = pc_f[DATA_WIDTH-1:IDX_W+2];
        w_lk_hit      = rst && valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
        pred_hit_f    = w_lk_hit;
        pred_taken_f  = w_lk_hit && (jump_q[w_lk_idx] || ctr_q[w_lk_idx][1]);
        pred_target_f = pred_taken_f ? target_q[w_lk_idx] : (pc_f + c_pc_step);
        pred_idx_f    = w_lk_idx;
    end

    // Training: one entry at upd_idx_e is refreshed, allocated or left alone
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        jump_d    = jump_q;
        ctr_d     = ctr_q;
        w_upd_tag = upd_pc_e[DATA_WIDTH-1:IDX_W+2];
        w_upd_hit = valid_q[upd_idx_e] && (tag_q[upd_idx_e] == w_upd_tag);
        if (upd_valid_e) begin
            if (w_upd_hit) begin
                if (upd_is_jump_e) begin
                    target_d[upd_idx_e] = upd_target_e;
                    ctr_d[upd_idx_e]    = 2'b11;
                end else if (upd_taken_e) begin
                    target_d[upd_idx_e] = upd_target_e;
                    if (ctr_q[upd_idx_e] != 2'b11) begin
                        ctr_d[upd_idx_e] = ctr_q[upd_idx_e] + 2'd1;
                    end
                end else if (ctr_q[upd_idx_e] != 2'b00) begin
                    ctr_d[upd_idx_e] = ctr_q[upd_idx_e] - 2'd1;
                end
            end else if (upd_taken_e) begin
                // Only taken outcomes earn a slot; a not-taken miss would just predict fall-through anyway
                valid_d[upd_idx_e]  = 1'b1;
                tag_d[upd_idx_e]    = w_upd_tag;
                target_d[upd_idx_e] = upd_target_e;
                jump_d[upd_idx_e]   = upd_is_jump_e;
                ctr_d[upd_idx_e]    = upd_is_jump_e ? 2'b11 : 2'b10;
            end
        end
    end

    // History shift (conditional branches only) and saturating perf counters
    always_comb begin
        ghr_d    = ghr_q;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (MODE == 1 && upd_valid_e && !upd_is_jump_e) begin
            ghr_d = HIST_BITS'({ghr_q, upd_taken_e});
        end
        if (upd_valid_e && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end
        if (upd_valid_e && upd_mispred_e && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    // State registers; reset wins over any concurrent update
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
                ctr_q[i]    <= 2'b01;
            end
            ghr_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            jump_q   <= jump_d;
            ctr_q    <= ctr_d;
            ghr_q    <= ghr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign perf_branch_cnt  = br_cnt_q;
    assign perf_mispred_cnt = mp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Checks a bimodal instance (3-bit perf counters) and a gshare
//               instance side by side against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [31:0] pc_f = 32'h100;
    logic        upd_valid_e = 1'b0;
    logic [31:0] upd_pc_e = '0;
    logic [3:0]  upd_idx_b = '0;
    logic [3:0]  upd_idx_g = '0;
    logic        upd_is_jump_e = 1'b0;
    logic        upd_taken_e = 1'b0;
    logic [31:0] upd_target_e = '0;
    logic        upd_mispred_e = 1'b0;

    logic        b_taken, b_hit, g_taken, g_hit;
    logic [31:0] b_target, g_target;
    logic [3:0]  b_idx, g_idx;
    logic [2:0]  b_br, b_mp;
    logic [31:0] g_br, g_mp;

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(0), .HIST_BITS(4), .CNT_W(3)) u_bim (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(b_taken), .pred_target_f(b_target), .pred_hit_f(b_hit), .pred_idx_f(b_idx),
        .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_idx_e(upd_idx_b),
        .upd_is_jump_e(upd_is_jump_e), .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
        .upd_mispred_e(upd_mispred_e), .perf_branch_cnt(b_br), .perf_mispred_cnt(b_mp)
    );

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(1), .HIST_BITS(4), .CNT_W(32)) u_gsh (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(g_taken), .pred_target_f(g_target), .pred_hit_f(g_hit), .pred_idx_f(g_idx),
        .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_idx_e(upd_idx_g),
        .upd_is_jump_e(upd_is_jump_e), .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
        .upd_mispred_e(upd_mispred_e), .perf_branch_cnt(g_br), .perf_mispred_cnt(g_mp)
    );

    // Reference model: [0] = bimodal, [1] = gshare
    bit          m_valid [2][16];
    int unsigned m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    bit          m_jmp   [2][16];
    int          m_ctr   [2][16];
    int          m_ghr   [2];
    longint      m_br    [2];
    longint      m_mp    [2];
    longint      m_max   [2] = '{64'd7, 64'hFFFF_FFFF};
    bit          m_known = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic int midx(int m, logic [31:0] pc);
        return int'((pc >> 2) % 16) ^ m_ghr[m];
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Apply one rising edge to the model using the inputs currently driven
    task automatic model_edge();
        int i;
        bit hit;
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 16; k++) begin
                    m_valid[m][k] = 1'b0;
                    m_ctr[m][k]   = 1;
                end
                m_ghr[m] = 0;
                m_br[m]  = 0;
                m_mp[m]  = 0;
            end
            m_known = 1'b1;
        end else if (upd_valid_e) begin
            for (int m = 0; m < 2; m++) begin
                i   = (m == 0) ? int'(upd_idx_b) : int'(upd_idx_g);
                hit = m_valid[m][i] && (m_tag[m][i] == (upd_pc_e >> 6));
                if (hit) begin
                    if (upd_is_jump_e) begin
                        m_tgt[m][i] = upd_target_e;
                        m_ctr[m][i] = 3;
                    end else if (upd_taken_e) begin
                        m_tgt[m][i] = upd_target_e;
                        m_ctr[m][i] = (m_ctr[m][i] < 3) ? m_ctr[m][i] + 1 : 3;
                    end else begin
                        m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
                    end
                end else if (upd_taken_e) begin
                    m_valid[m][i] = 1'b1;
                    m_tag[m][i]   = upd_pc_e >> 6;
                    m_tgt[m][i]   = upd_target_e;
                    m_jmp[m][i]   = upd_is_jump_e;
                    m_ctr[m][i]   = upd_is_jump_e ? 3 : 2;
                end
                if (m == 1 && !upd_is_jump_e) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken_e)) % 16;
                m_br[m] = (m_br[m] < m_max[m]) ? m_br[m] + 1 : m_max[m];
                if (upd_mispred_e) m_mp[m] = (m_mp[m] < m_max[m]) ? m_mp[m] + 1 : m_max[m];
            end
        end
    endtask

    // Compare every DUT output with the model's view of the current pc_f
    task automatic model_check();
        int i;
        bit hit, tk;
        logic [31:0] tg;
        string p;
        for (int m = 0; m < 2; m++) begin
            p   = (m == 0) ? "bim" : "gsh";
            i   = midx(m, pc_f);
            hit = rst && m_valid[m][i] && (m_tag[m][i] == (pc_f >> 6));
            tk  = hit && (m_jmp[m][i] || m_ctr[m][i] >= 2);
            tg  = tk ? m_tgt[m][i] : pc_f + 32'd4;
            chk({p, "_hit"},    (m == 0) ? b_hit : g_hit, 64'(hit));
            chk({p, "_taken"},  (m == 0) ? b_taken : g_taken, 64'(tk));
            chk({p, "_target"}, (m == 0) ? b_target : g_target, 64'(tg));
            if (m_known) begin
                chk({p, "_idx"},    (m == 0) ? 64'(b_idx) : 64'(g_idx), 64'(i));
                chk({p, "_br_cnt"}, (m == 0) ? 64'(b_br) : 64'(g_br), 64'(m_br[m]));
                chk({p, "_mp_cnt"}, (m == 0) ? 64'(b_mp) : 64'(g_mp), 64'(m_mp[m]));
            end
        end
    endtask

    task automatic step(logic [31:0] pc, logic v, logic [31:0] upc, logic j, logic t,
                        logic [31:0] tg, logic mp);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        pc_f          = pc;
        upd_valid_e   = v;
        upd_pc_e      = upc;
        upd_is_jump_e = j;
        upd_taken_e   = t;
        upd_target_e  = tg;
        upd_mispred_e = mp;
        upd_idx_b     = 4'(midx(0, upc));
        upd_idx_g     = 4'(midx(1, upc));
        #1;
        model_check();
    endtask

    task automatic look(logic [31:0] pc);
        step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // Reset with a concurrent update: table must stay empty
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("rst_hit", b_hit, 1'b0);
        look(32'h100);
        rst = 1'b1;
        look(32'h100);
        chk("reset_hit", b_hit, 1'b0);
        chk("reset_taken", b_taken, 1'b0);
        chk("reset_target", b_target, 32'h104);
        chk("reset_br", b_br, 3'd0);

        // Allocate, then walk the counter down
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1);
        look(32'h100);
        chk("train_taken", b_taken, 1'b1);
        chk("train_target", b_target, 32'h80);
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("nt_taken", b_taken, 1'b0);
        chk("nt_target", b_target, 32'h104);

        // Saturate high, one not-taken still predicts taken
        for (int k = 0; k < 4; k++) step(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        step(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("sat_taken", b_taken, 1'b1);

        // Aliasing: 0x140 steals the slot, a not-taken miss at 0x180 changes nothing
        step(32'h100, 1'b1, 32'h140, 1'b0, 1'b1, 32'h240, 1'b0);
        look(32'h100);
        chk("alias_old_hit", b_hit, 1'b0);
        look(32'h140);
        chk("alias_new_target", b_target, 32'h240);
        step(32'h140, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h140);
        chk("alias_keep_target", b_target, 32'h240);

        // Same-cycle update and lookup: old contents now, new contents next cycle
        step(32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0);
        chk("coll_same_hit", b_hit, 1'b0);
        look(32'h300);
        chk("coll_next_target", b_target, 32'h500);

        // PC+4 wrap
        look(32'hFFFF_FFFC);
        chk("wrap_target", b_target, 32'h0);

        // Fresh reset, then GHR pattern T,T,N,T and a jump
        rst = 1'b0;
        look(32'h100);
        rst = 1'b1;
        look(32'h100);
        step(32'h100, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b1);
        step(32'h100, 1'b1, 32'h14, 1'b0, 1'b1, 32'h24, 1'b0);
        step(32'h100, 1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 1'b1);
        step(32'h100, 1'b1, 32'h1C, 1'b0, 1'b1, 32'h28, 1'b0);
        look(32'h100);
        chk("ghr_idx", g_idx, 4'hD);
        step(32'h100, 1'b1, 32'h30, 1'b1, 1'b1, 32'h40, 1'b0);
        look(32'h100);
        chk("ghr_jump_idx", g_idx, 4'hD);
        chk("perf_br5", b_br, 3'd5);
        chk("perf_mp2", b_mp, 3'd2);
        for (int k = 0; k < 4; k++) step(32'h100, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        chk("perf_sat_bim", b_br, 3'd7);
        chk("perf_gsh9", g_br, 32'd9);

        // Randomized traffic over 32 PCs sharing 16 slots, with occasional resets
        for (int k = 0; k < 500; k++) begin
            logic [31:0] pc, upc;
            rst = ($urandom_range(0, 59) != 0);
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h100 + 32'(4 * $urandom_range(0, 31));
            upc = 32'h100 + 32'(4 * $urandom_range(0, 31));
            step(pc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 2) != 0), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
        end
        rst = 1'b1;
        look(32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
